// File: rtl/wb_pipelined_responder_pkg.sv
// Shared types and helpers for the pipelined Wishbone responder.
//   t_wishbone_slave_in  : cyc, stb, we, sel[3:0], adr[31:0] (byte address), dat[31:0]
//   t_wishbone_slave_out : ack, err, rty, stall, dat[31:0]
//   t_resp_stage         : one slot of the response delay line
//   f_addr_legal         : word-aligned and inside the bank
package wb_responder_pkg;

    localparam int c_max_latency = 8;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } t_wishbone_slave_in;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        stall;
        logic [31:0] dat;
    } t_wishbone_slave_out;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] dat;
    } t_resp_stage;

    // Legal iff the two byte-offset bits and every bit above the word index are zero.
    function automatic logic f_addr_legal(input logic [31:0] adr, input int addr_bits);
        logic [31:0] index_mask;
        index_mask = ((32'd1 << (addr_bits + 2)) - 32'd1) & ~32'd3;
        return (adr & ~index_mask) == 32'd0;
    endfunction

endpackage

// File: rtl/wb_resp_delay_line.sv
// Fixed-depth shift register carrying responses from accept to the bus.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-high reset
//   flush          : synchronous clear of every stage (bus cycle dropped)
//   din            : response entering at accept
//   dout           : response presented on the bus this cycle
//   advance        : a valid entry moves into the output stage at the next edge
module wb_resp_delay_line
    import wb_responder_pkg::*;
#(
    parameter int g_latency = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush,
    input  t_resp_stage din,
    output t_resp_stage dout,
    output logic        advance
);

    t_resp_stage stage_reg [g_latency];
    t_resp_stage stage_src [g_latency];

    generate
        for (genvar gi = 0; gi < g_latency; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_src[gi] = din;
            end else begin : g_chain
                assign stage_src[gi] = stage_reg[gi-1];
            end

            always_ff @(posedge clk_i or posedge rst_n_i) begin
                if (rst_n_i) begin
                    stage_reg[gi] <= '0;
                end else if (flush) begin
                    stage_reg[gi] <= '0;
                end else begin
                    stage_reg[gi] <= stage_src[gi];
                end
            end
        end
    endgenerate

    assign dout    = stage_reg[g_latency-1];
    // Entries are counted as outstanding until they reach the output stage,
    // so the slot frees one cycle before the response is driven. This lets
    // g_max_outstanding = g_latency stream one request per cycle.
    assign advance = stage_src[g_latency-1].valid;

endmodule

// File: rtl/wb_pipelined_responder.sv
// Wishbone B4 pipelined slave with fixed response latency.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-high reset
//   slave_i        : Wishbone request (byte address)
//   slave_o        : ack / err / rty(=0) / stall / read data
//   stall_force_i  : external back-pressure, ORed into stall
//   accept_cnt_o   : wrapping count of accepted requests
//   err_cnt_o      : wrapping count of err responses
module wb_pipelined_responder
    import wb_responder_pkg::*;
#(
    parameter int g_addr_bits       = 4,
    parameter int g_latency         = 2,
    parameter int g_max_outstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  t_wishbone_slave_in  slave_i,
    output t_wishbone_slave_out slave_o,
    input  logic                stall_force_i,
    output logic [15:0]         accept_cnt_o,
    output logic [15:0]         err_cnt_o
);

    localparam int c_words = 2 ** g_addr_bits;
    localparam int c_cnt_w = $clog2(c_max_latency + 1);

    logic                   stall;
    logic                   accept;
    logic                   legal;
    logic                   wr_en;
    logic                   advance;
    logic                   resp_valid;
    logic                   ack_resp;
    logic                   err_resp;
    logic [3:0]             lane_we;
    logic [g_addr_bits-1:0] word_idx;
    logic [31:0]            rd_word;
    logic [31:0]            bank_reg [c_words];
    logic [c_cnt_w-1:0]     cnt_reg;
    logic [c_cnt_w-1:0]     cnt_next;
    logic [15:0]            accept_cnt_reg;
    logic [15:0]            err_cnt_reg;
    t_resp_stage            stage_in;
    t_resp_stage            stage_out;

    // Request decode
    assign word_idx = slave_i.adr[g_addr_bits+1:2];
    assign legal    = f_addr_legal(slave_i.adr, g_addr_bits);
    assign stall    = stall_force_i | (cnt_reg == c_cnt_w'(g_max_outstanding));
    assign accept   = slave_i.cyc & slave_i.stb & ~stall;
    assign wr_en    = accept & legal & slave_i.we;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = wr_en & slave_i.sel[gi];
        end
    endgenerate

    // Register bank: byte-lane writes commit at the accept edge
    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            for (int w = 0; w < c_words; w++) begin
                bank_reg[w] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (lane_we[b]) begin
                    bank_reg[word_idx][b*8 +: 8] <= slave_i.dat[b*8 +: 8];
                end
            end
        end
    end

    // Read data is captured at accept; at most one accept per cycle, so a
    // read never races a write to the bank in the same cycle.
    assign rd_word = bank_reg[word_idx];

    always_comb begin
        stage_in       = '0;
        stage_in.valid = accept;
        stage_in.err   = ~legal;
        stage_in.dat   = (legal & ~slave_i.we) ? rd_word : 32'd0;
    end

    wb_resp_delay_line #(
        .g_latency (g_latency)
    ) u_delay (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush   (~slave_i.cyc),
        .din     (stage_in),
        .dout    (stage_out),
        .advance (advance)
    );

    // Nothing is driven back while cyc is low, even in the cycle of the drop
    assign resp_valid = stage_out.valid & slave_i.cyc;
    assign ack_resp   = resp_valid & ~stage_out.err;
    assign err_resp   = resp_valid & stage_out.err;

    always_comb begin
        slave_o       = '0;
        slave_o.ack   = ack_resp;
        slave_o.err   = err_resp;
        slave_o.rty   = 1'b0;
        slave_o.stall = stall;
        slave_o.dat   = ack_resp ? stage_out.dat : 32'd0;
    end

    // Outstanding counter
    always_comb begin
        cnt_next = cnt_reg;
        if (!slave_i.cyc) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + c_cnt_w'(accept) - c_cnt_w'(advance);
        end
    end

    always_ff @(posedge clk_i or posedge rst_n_i) begin
        if (rst_n_i) begin
            cnt_reg        <= '0;
            accept_cnt_reg <= '0;
            err_cnt_reg    <= '0;
        end else begin
            cnt_reg        <= cnt_next;
            accept_cnt_reg <= accept_cnt_reg + 16'(accept);
            err_cnt_reg    <= err_cnt_reg + 16'(err_resp);
        end
    end

    assign accept_cnt_o = accept_cnt_reg;
    assign err_cnt_o    = err_cnt_reg;

endmodule

// File: tb/tb_wb_pipelined_responder.sv
module tb_wb_pipelined_responder;
    import wb_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    t_wishbone_slave_in  s_in  [3];
    t_wishbone_slave_out s_out [3];
    logic                sf    [3];
    logic [15:0]         acnt  [3];
    logic [15:0]         ecnt  [3];

    logic [31:0] model [3][16];

    typedef struct {
        int          d;
        int          due;
        logic        err;
        logic [31:0] dat;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // dut 0: latency 2 / max 2, dut 1: latency 3 / max 3, dut 2: latency 3 / max 1
    wb_pipelined_responder #(.g_addr_bits(4), .g_latency(2), .g_max_outstanding(2)) dut_a (
        .clk_i(clk), .rst_n_i(rst), .slave_i(s_in[0]), .slave_o(s_out[0]),
        .stall_force_i(sf[0]), .accept_cnt_o(acnt[0]), .err_cnt_o(ecnt[0]));
    wb_pipelined_responder #(.g_addr_bits(4), .g_latency(3), .g_max_outstanding(3)) dut_b (
        .clk_i(clk), .rst_n_i(rst), .slave_i(s_in[1]), .slave_o(s_out[1]),
        .stall_force_i(sf[1]), .accept_cnt_o(acnt[1]), .err_cnt_o(ecnt[1]));
    wb_pipelined_responder #(.g_addr_bits(4), .g_latency(3), .g_max_outstanding(1)) dut_c (
        .clk_i(clk), .rst_n_i(rst), .slave_i(s_in[2]), .slave_o(s_out[2]),
        .stall_force_i(sf[2]), .accept_cnt_o(acnt[2]), .err_cnt_o(ecnt[2]));

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic adr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:6] == 26'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Present one request and hold it until accepted; pushes the expected response.
    task automatic issue(input int d, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] wdat, input logic exp_err, input logic [31:0] exp_dat,
                         output int acc);
        exp_t e;
        s_in[d].cyc = 1'b1;
        s_in[d].stb = 1'b1;
        s_in[d].we  = we;
        s_in[d].adr = adr;
        s_in[d].sel = sel;
        s_in[d].dat = wdat;
        acc = -1;
        for (int t = 0; t < 40 && acc < 0; t++) begin
            @(negedge clk);
            if (!s_out[d].stall) begin
                acc = cycle;
                e.d = d; e.due = cycle + lat(d); e.err = exp_err; e.dat = exp_dat;
                sb.push_back(e);
            end
            @(posedge clk); #1;
        end
        s_in[d].stb = 1'b0;
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input int d, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] v, output int acc);
        if (adr_ok(adr)) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[d][adr[5:2]][b*8 +: 8] = v[b*8 +: 8];
        end
        issue(d, 1'b1, adr, sel, v, !adr_ok(adr), 32'd0, acc);
    endtask

    task automatic rd(input int d, input logic [31:0] adr, output int acc);
        issue(d, 1'b0, adr, 4'hF, 32'd0, !adr_ok(adr),
              adr_ok(adr) ? model[d][adr[5:2]] : 32'd0, acc);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (!s_in[d].cyc) chk("resp_while_idle", {30'd0, s_out[d].ack, s_out[d].err}, 32'd0);
                if (s_out[d].ack || s_out[d].err) begin
                    chk("ack_err_excl", {31'd0, s_out[d].ack & s_out[d].err}, 32'd0);
                    chk("rty_zero", {31'd0, s_out[d].rty}, 32'd0);
                    if (sb.size() == 0 || sb[0].d != d) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("resp_cycle", cycle, e.due);
                        chk("resp_err", {31'd0, s_out[d].err}, {31'd0, e.err});
                        chk("resp_ack", {31'd0, s_out[d].ack}, {31'd0, !e.err});
                        chk("resp_dat", s_out[d].dat, e.dat);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int acc_c [6];
        int need;
        for (int d = 0; d < 3; d++) begin
            s_in[d] = '0;
            sf[d] = 1'b0;
            for (int w = 0; w < 16; w++) model[d][w] = 32'd0;
        end
        sf[1] = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ack", {31'd0, s_out[d].ack}, 32'd0);
            chk("rst_err", {31'd0, s_out[d].err}, 32'd0);
            chk("rst_rty", {31'd0, s_out[d].rty}, 32'd0);
            chk("rst_dat", s_out[d].dat, 32'd0);
            chk("rst_stall", {31'd0, s_out[d].stall}, {31'd0, sf[d]});
            chk("rst_acnt", {16'd0, acnt[d]}, 32'd0);
            chk("rst_ecnt", {16'd0, ecnt[d]}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        sf[1] = 1'b0;
        @(posedge clk); #1;

        // Write then read, back to back
        wr(0, 32'h8, 4'hF, 32'hDEADBEEF, c);
        rd(0, 32'h8, c);
        chk("acnt_after_wr_rd", {16'd0, acnt[0]}, 32'd2);
        drain();

        // Byte lanes
        wr(0, 32'h4, 4'hF, 32'h11223344, c);
        wr(0, 32'h4, 4'b0101, 32'hAABBCCDD, c);
        rd(0, 32'h4, c);
        drain();

        // Illegal addresses
        rd(0, 32'h2, c);
        rd(0, 32'h40, c);
        drain();
        chk("ecnt_two", {16'd0, ecnt[0]}, 32'd2);
        wr(0, 32'h48, 4'hF, 32'h0BAD0BAD, c);
        rd(0, 32'h8, c);
        rd(0, 32'h0, c);
        drain();
        chk("ecnt_three", {16'd0, ecnt[0]}, 32'd3);

        // Forced stall blocks acceptance
        need = acnt[0];
        sf[0] = 1'b1;
        s_in[0].cyc = 1'b1; s_in[0].stb = 1'b1; s_in[0].we = 1'b0; s_in[0].adr = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_forced", {31'd0, s_out[0].stall}, 32'd1);
        end
        @(posedge clk); #1;
        chk("no_accept_forced", {16'd0, acnt[0]}, need);
        sf[0] = 1'b0;
        s_in[0].stb = 1'b0;

        // Abort on dut 1: drop cyc right after two accepts
        rd(1, 32'h8, c);
        rd(1, 32'h4, c);
        s_in[1].cyc = 1'b0;
        void'(sb.pop_back());
        void'(sb.pop_back());
        @(posedge clk); #1;
        s_in[1].cyc = 1'b1;
        @(negedge clk);
        chk("abort_stall", {31'd0, s_out[1].stall}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        rd(1, 32'h8, c);
        drain();

        // Back-to-back on dut 1: six reads, one per cycle, no stall
        wr(1, 32'hC, 4'hF, 32'h12345678, c);
        drain();
        for (int i = 0; i < 6; i++) rd(1, 32'(i * 4), acc_c[i]);
        for (int i = 1; i < 6; i++) chk("b2b_accept_cycle", acc_c[i], acc_c[0] + i);
        drain();

        // Outstanding limit on dut 2: one request every 3 cycles
        for (int i = 0; i < 4; i++) rd(2, 32'(i * 4), acc_c[i]);
        for (int i = 1; i < 4; i++) chk("limit_accept_gap", acc_c[i] - acc_c[i-1], 32'd3);
        drain();

        // Reset mid transfer: no response for the pre-reset accept
        rd(0, 32'h8, c);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_acnt", {16'd0, acnt[0]}, 32'd0);
        chk("async_rst_ack", {31'd0, s_out[0].ack}, 32'd0);
        void'(sb.pop_back());
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 16; w++) model[d][w] = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rd(0, 32'h8, c);
        drain();

        // Accept counter wrap
        need = 16'hFFFF - acnt[0];
        for (int i = 0; i < need; i++) rd(0, 32'h0, c);
        chk("acnt_ffff", {16'd0, acnt[0]}, 32'h0000FFFF);
        rd(0, 32'h0, c);
        chk("acnt_wrap", {16'd0, acnt[0]}, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
